// File: rtl/mmio_uart_tx_if.sv
// rtl/mmio_uart_tx_if.sv - data-memory port bundle between the core and the MMIO UART transmitter
interface mmio_uart_tx_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  sel;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  write_en;
    logic [3:0]            mask;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;

    modport master (
        output sel, addr, write_en, mask, data_in,
        input  data_out
    );

    modport slave (
        input  sel, addr, write_en, mask, data_in,
        output data_out
    );
endinterface

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with TX FIFO and status register
// Optional even-parity bit between data and stop when UART_TX_PARITY_EN is defined.
module mmio_uart_tx #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h8000_0000,
    parameter int                    CLKS_PER_BIT = 16,
    parameter int                    FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mmio_uart_tx_if.slave        bus,
    output logic                 uart_tx,
    output logic                 irq_empty
);

    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]  BAUD_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [FCNT_W-1:0] FIFO_FULL   = FCNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               parity_q, parity_d;
    logic               tx_q, tx_d;

    logic [7:0]         fifo_q [FIFO_DEPTH];
    logic [7:0]         fifo_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [FCNT_W-1:0]  count_q, count_d;
    logic               ovf_q, ovf_d;

    logic               pop;
    logic               push_req;
    logic               clr_req;
    logic               push_ok;
    logic               ovf_set;
    logic               fifo_full;
    logic               fifo_empty;
    logic               baud_done;
    logic [DATA_WIDTH-1:0] status;

    assign fifo_full  = (count_q == FIFO_FULL);
    assign fifo_empty = (count_q == '0);
    assign baud_done  = (baud_q == '0);

    // Only addr[2] selects between TXDATA and STATUS; the decoder owns the rest of the window.
    assign push_req = bus.sel & bus.write_en & ~bus.addr[2] & bus.mask[0];
    assign clr_req  = bus.sel & bus.write_en &  bus.addr[2] & bus.mask[0];

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        pop      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    shift_d  = fifo_q[rd_ptr_q];
                    parity_d = ^fifo_q[rd_ptr_q];
                    baud_d   = BAUD_RELOAD;
                    state_d  = S_START;
                end
            end
            S_START: begin
                if (baud_done) begin
                    baud_d  = BAUD_RELOAD;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            S_DATA: begin
                if (baud_done) begin
                    baud_d = BAUD_RELOAD;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_done) begin
                    baud_d  = BAUD_RELOAD;
                    state_d = S_STOP;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
`endif
            S_STOP: begin
                // Counter is left at zero on exit so IDLE lasts exactly one cycle when more data waits.
                if (baud_done) begin
                    state_d = S_IDLE;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
            end
        endcase
    end

    // Line level is registered from the next state so the pin is glitch-free.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = parity_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    always_comb begin
        // A push into a full FIFO survives only if the transmitter frees a slot on the same edge.
        push_ok = push_req & (~fifo_full | pop);
        ovf_set = push_req & fifo_full & ~pop;

        fifo_d = fifo_q;
        if (push_ok) begin
            fifo_d[wr_ptr_q] = bus.data_in[7:0];
        end

        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);

        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (clr_req) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    always_comb begin
        status        = '0;
        status[0]     = (state_q != S_IDLE);
        status[1]     = fifo_full;
        status[2]     = fifo_empty;
        status[3]     = ovf_q;
`ifdef UART_TX_PARITY_EN
        status[4]     = 1'b1;
`else
        status[4]     = 1'b0;
`endif
        status[15:8]  = 8'(count_q);
    end

    assign bus.data_out = (bus.sel && !bus.write_en && bus.addr[2]) ? status : '0;
    assign uart_tx      = tx_q;
    assign irq_empty    = fifo_empty & (state_q == S_IDLE);

    logic unused_ok;
    assign unused_ok = ^{bus.addr[ADDR_WIDTH-1:3], bus.addr[1:0],
                         bus.data_in[DATA_WIDTH-1:8], bus.mask[3:1], BASE_ADDR};

endmodule
